tbird_input_cond: RTL and testbench

TBIRD_INPUT_COND -- requirements
Module: tbird_input_cond

---
 rtl/tbird_input_cond.sv | 96 +++++++++
 tb/tb_tbird_input_cond.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tbird_input_cond.sv
// Switch conditioning for the turn-indicator: synchronize, debounce,
// resolve left/right/hazard priority and generate the sequencer step.
module tbird_input_cond #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned TICK_DIV  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic left_sw,
  input  logic right_sw,
  input  logic haz_sw,
  output logic left,
  output logic right,
  output logic haz,
  output logic step
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] TCK_MAX = TW'(TICK_DIV - 1);

  // channel index: 0 = left, 1 = right, 2 = hazard
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    db;
  logic [CW-1:0] cnt [3];

  assign raw = {haz_sw, right_sw, left_sw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic req_haz;
  logic req_left;
  logic req_right;
  logic active;
  logic change;

  // both directions at once is promoted to hazard
  always_comb begin
    req_haz   = db[2] | (db[0] & db[1]);
    req_left  = db[0] & ~req_haz;
    req_right = db[1] & ~req_haz;
    active    = req_haz | req_left | req_right;
    change    = {req_haz, req_left, req_right} != {haz, left, right};
  end

  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left  <= 1'b0;
      right <= 1'b0;
      haz   <= 1'b0;
      step  <= 1'b0;
      tcnt  <= '0;
    end else begin
      left  <= req_left;
      right <= req_right;
      haz   <= req_haz;
      // a new request restarts the step phase from zero
      if (!active || change) begin
        tcnt <= '0;
        step <= 1'b0;
      end else if (tcnt == TCK_MAX) begin
        tcnt <= '0;
        step <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
        step <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tbird_input_cond.sv
// Bench for tbird_input_cond: directed scenarios plus random bouncing,
// checked every cycle against a window-based reference model.
module tb_tbird_input_cond;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic left_sw = 1'b0;
  logic right_sw = 1'b0;
  logic haz_sw = 1'b0;
  logic left;
  logic right;
  logic haz;
  logic step;

  always #5 clk = ~clk;

  tbird_input_cond #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk),
    .reset(reset),
    .left_sw(left_sw),
    .right_sw(right_sw),
    .haz_sw(haz_sw),
    .left(left),
    .right(right),
    .haz(haz),
    .step(step)
  );

  int total = 0;
  int bad = 0;

  // model: bit 0 = left, 1 = right, 2 = hazard
  bit [2:0]  ms1, ms2, mdb, mout;
  bit [31:0] win [3];
  bit        mstep;
  int        since;
  int        cyc = 0;
  int        last_step = -1;
  int        last_chg = 0;
  logic [2:0] prev_o = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit [2:0] resolve(input bit [2:0] d);
    if (d[2] || (d[0] && d[1])) return 3'b100;
    return {1'b0, d[1], d[0]};
  endfunction

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mdb = '0; mout = '0;
    mstep = 1'b0; since = 0;
    for (int i = 0; i < 3; i++) win[i] = '0;
  endtask

  // a level is accepted once the last DB synchronized samples all disagree
  task automatic model_edge(input bit [2:0] rawv);
    bit [2:0]  nout;
    bit [31:0] m;
    m = (32'd1 << DB) - 32'd1;
    nout = resolve(mdb);
    for (int i = 0; i < 3; i++) begin
      win[i] = {win[i][30:0], ms2[i]};
      if ((win[i] & m) == (mdb[i] ? 32'd0 : m)) mdb[i] = ~mdb[i];
    end
    ms2 = ms1;
    ms1 = rawv;
    if (nout != mout) since = 0;
    else since++;
    mout = nout;
    mstep = (mout != 0) && (since != 0) && (since % TD == 0);
  endtask

  task automatic tick();
    logic [2:0] o;
    @(posedge clk);
    #1;
    cyc++;
    if (!reset) model_reset();
    else model_edge({haz_sw, right_sw, left_sw});
    check("left", left, mout[0]);
    check("right", right, mout[1]);
    check("haz", haz, mout[2]);
    check("step", step, mstep);
    o = {haz, right, left};
    check("onehot", $countones(o) <= 1, 1);
    if (step) check("step_idle", |o, 1);
    if (o != prev_o) last_chg = cyc;
    prev_o = o;
    if (step) begin
      if (last_step > last_chg) check("spacing", cyc - last_step, TD);
      last_step = cyc;
    end
  endtask

  task automatic wait_for(input int which, input string tag, input int exp);
    int n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 64) begin
      tick();
      n++;
      case (which)
        0: hit = left;
        1: hit = right;
        2: hit = haz;
        default: hit = step;
      endcase
    end
    check(tag, n, exp);
  endtask

  initial begin
    logic seen;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;

    // right turn: accept latency then periodic step
    right_sw = 1'b1;
    wait_for(1, "right_lat", DB + 3);
    wait_for(3, "right_step1", TD);
    wait_for(3, "right_step2", TD);
    check("right_nohaz", haz, 0);
    right_sw = 1'b0;
    repeat (12) tick();

    // short left pulses are rejected
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      left_sw = 1'b1;
      repeat (3) begin tick(); seen = seen | left | step; end
      left_sw = 1'b0;
      repeat (5) begin tick(); seen = seen | left | step; end
    end
    check("glitch", seen, 0);

    // left then right -> promoted to hazard
    left_sw = 1'b1;
    wait_for(0, "left_lat", DB + 3);
    repeat (3) tick();
    right_sw = 1'b1;
    wait_for(2, "conf_lat", DB + 3);
    check("conf_left", {left, right}, 0);
    wait_for(3, "conf_step", TD);

    // hazard switch over left, then release back to left
    right_sw = 1'b0;
    haz_sw = 1'b1;
    repeat (10) tick();
    check("haz_hold", {haz, left}, 2'b10);
    haz_sw = 1'b0;
    wait_for(0, "haz_rel", DB + 3);
    check("haz_off", haz, 0);
    wait_for(3, "haz_rel_step", TD);

    // reset in the middle of a step count
    left_sw = 1'b0;
    right_sw = 1'b1;
    wait_for(1, "pre_rst", DB + 3);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_out", {haz, right, left, step}, 0);
    tick();
    reset = 1'b1;
    wait_for(1, "post_rst_lat", DB + 3);
    wait_for(3, "post_rst_step", TD);

    // random bouncing
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 5) == 0) left_sw = ~left_sw;
      if ($urandom_range(0, 5) == 0) right_sw = ~right_sw;
      if ($urandom_range(0, 7) == 0) haz_sw = ~haz_sw;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
